mul_seq: RTL and testbench

Iterative shift-add multiplier sequencer that computes a 32x32 product (low 32 bits) by driving the core's single-cycle ALU one operation per clock. It does not instantiate its own adder. It sequences the existing ALU through ADD, shift-left and shift-right operations, so M-extension-style multiplies reuse the execute datapath. It sits beside the ALU in the execute stage and owns the ALU input mux while busy.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu.sv | 29 ++
 rtl/mul_seq.sv | 115 +++++++++++
 tb/tb_mul_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions.
// Used by the ALU decoder, the shared ALU, mul_seq and the bench.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd7;

endpackage

// File: rtl/alu.sv
// Single-cycle execute-stage ALU, purely combinational.
// Ports:
//   alu_control - 4-bit opcode (alu_pkg)
//   a, b        - 32-bit operands (rs1, rs2)
//   ans         - 32-bit result; shifts use b[4:0]; unused opcodes give 0
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  alu_control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] ans
);

  always_comb begin
    ans = '0;
    case (alu_control)
      ALU_AND: ans = a & b;
      ALU_OR:  ans = a | b;
      ALU_ADD: ans = a + b;
      ALU_SLL: ans = a << b[4:0];
      ALU_SUB: ans = a - b;
      ALU_SRL: ans = a >> b[4:0];
      ALU_XOR: ans = a ^ b;
      default: ans = '0;
    endcase
  end

endmodule

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier sequencer. Produces the low 32 bits of
// op_a*op_b by stepping the shared execute ALU through ADD, SLL and SRL,
// one operation per clock, 32 iterations (96 busy cycles) per multiply.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - request, accepted only in IDLE
//   op_a, op_b   - multiplicand / multiplier, captured on accept
//   busy         - high while sequencing the ALU
//   done         - one-cycle pulse when result becomes valid
//   result       - registered product, held until next accept
//   alu_control, alu_a, alu_b - drive to the shared ALU
//   alu_ans      - combinational ALU result, consumed same cycle
module mul_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_ans
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] acc, mcand, mplier;
  logic [4:0]  iter;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      iter   <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            iter   <= '0;
            result <= '0;
          end
        end
        S_ADD: begin
          if (mplier[0]) acc <= alu_ans;
        end
        S_SHL: mcand <= alu_ans;
        S_SHR: begin
          mplier <= alu_ans;
          // acc was last written in the ADD two cycles ago, so it is final here
          if (iter == 5'd31) result <= acc;
          else               iter   <= iter + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    alu_control = ALU_AND;
    alu_a       = '0;
    alu_b       = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_ADD;
      S_ADD: begin
        busy        = 1'b1;
        alu_control = ALU_ADD;
        alu_a       = acc;
        alu_b       = mcand;
        state_nxt   = S_SHL;
      end
      S_SHL: begin
        busy        = 1'b1;
        alu_control = ALU_SLL;
        alu_a       = mcand;
        alu_b       = 32'd1;
        state_nxt   = S_SHR;
      end
      S_SHR: begin
        busy        = 1'b1;
        alu_control = ALU_SRL;
        alu_a       = mplier;
        alu_b       = 32'd1;
        state_nxt   = (iter == 5'd31) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq closed around the shared alu.
module tb_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_ans;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mul_seq u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .alu_control (alu_control),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ans     (alu_ans)
  );

  alu u_alu (
    .alu_control (alu_control),
    .a           (alu_a),
    .b           (alu_b),
    .ans         (alu_ans)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic [31:0] exp_result);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".done"}, {31'd0, done}, 32'd0);
    check({tag, ".ctl"}, {28'd0, alu_control}, {28'd0, ALU_AND});
    check({tag, ".alu_a"}, alu_a, 32'd0);
    check({tag, ".alu_b"}, alu_b, 32'd0);
    check({tag, ".result"}, result, exp_result);
  endtask

  // Accepts a start at cycle 0 and checks every cycle through 98.
  // With overlap set, a second start with other operands is raised at cycle 10.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit overlap, input string tag);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'h0BAD_F00D;
    for (int c = 1; c <= 97; c++) begin
      if (c <= 96) begin
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
      end else begin
        check({tag, ".done_busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done_pulse"}, {31'd0, done}, 32'd1);
        check({tag, ".result"}, result, exp);
        check({tag, ".done_ctl"}, {28'd0, alu_control}, {28'd0, ALU_AND});
      end
      if (c == 1) begin
        check({tag, ".c1_res"}, result, 32'd0);
        check({tag, ".c1_ctl"}, {28'd0, alu_control}, {28'd0, ALU_ADD});
        check({tag, ".c1_a"}, alu_a, 32'd0);
        check({tag, ".c1_b"}, alu_b, a);
      end
      if (c == 2) begin
        check({tag, ".c2_ctl"}, {28'd0, alu_control}, {28'd0, ALU_SLL});
        check({tag, ".c2_a"}, alu_a, a);
        check({tag, ".c2_b"}, alu_b, 32'd1);
      end
      if (c == 3) begin
        check({tag, ".c3_ctl"}, {28'd0, alu_control}, {28'd0, ALU_SRL});
        check({tag, ".c3_a"}, alu_a, b);
        check({tag, ".c3_b"}, alu_b, 32'd1);
      end
      if (overlap && c == 10) begin
        start = 1'b1;
        op_a  = 32'd100;
        op_b  = 32'd100;
      end
      tick();
      if (overlap && c == 10) start = 1'b0;
    end
    check_quiet({tag, ".c98"}, exp);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_quiet("reset", 32'd0);

    run_mul(32'd3, 32'd5, 32'd15, 1'b0, "m3x5");
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mff");
    run_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, "m2p16");
    run_mul(32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, "mzero");
    run_mul(32'd7, 32'd6, 32'd42, 1'b1, "m7x6");

    for (int i = 0; i < 5; i++) tick();
    check_quiet("hold42", 32'd42);

    // Reset in the middle of an operation
    @(negedge clk);
    op_a  = 32'd100;
    op_b  = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 40; c++) tick();
    check("pre_rst.busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("mid_rst", 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check_quiet("post_rst", 32'd0);

    run_mul(32'd9, 32'd9, 32'd81, 1'b0, "m9x9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
